// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM states, NOP/halt encodings, IF/ID slot layout.
package fetch_unit_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic [31:0] INST_HALT    = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;
endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// Pipeline slot register (valid + pc + inst) with load, hold and flush-to-NOP.
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);
    always_ff @(posedge clk) begin
        if (reset) begin
            q.valid <= 1'b0;
            q.pc    <= 32'h0;
            q.inst  <= NOP_INST;
        end else if (flush) begin
            // pc is left as-is; only valid/inst define an empty slot
            q.valid <= 1'b0;
            q.inst  <= NOP_INST;
        end else if (load) begin
            q <= d;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, BOOT/RUN/HALT FSM, next-PC select, IF/ID capture.
// Optional misaligned-redirect checking is enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        halted,
    output logic        misalign_err
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q;
    logic [31:0]  redir_tgt;
    logic         redir_ok, redir_bad;
    logic         cap, flush, pc_inc;
    if_id_t       slot_d, slot_q;

`ifdef FETCH_MISALIGN_CHK_EN
    logic err_q;
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redir_tgt = redirect_pc;

    always_ff @(posedge clk) begin
        if (reset)          err_q <= 1'b0;
        else if (redir_bad) err_q <= 1'b1;
    end
    assign misalign_err = err_q;
`else
    logic unused_lo;
    assign unused_lo    = ^redirect_pc[1:0];
    assign redir_bad    = 1'b0;
    assign redir_tgt    = {redirect_pc[31:2], 2'b00};
    assign misalign_err = 1'b0;
`endif

    assign redir_ok = redirect_valid && !redir_bad;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_BOOT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (redir_ok)       state_d = ST_RUN;
        else if (redir_bad) state_d = ST_HALT;
        else begin
            case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN:  if (!stall && imem_inst == INST_HALT) state_d = ST_HALT;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_BOOT;
            endcase
        end
    end

    // Any redirect (good or bad) flushes; the word on imem_inst is dropped.
    always_comb begin
        cap    = 1'b0;
        pc_inc = 1'b0;
        flush  = redirect_valid;
        halted = (state_q == ST_HALT);
        if (!redirect_valid && state_q == ST_RUN && !stall) begin
            if (imem_inst == INST_HALT) begin
                flush = 1'b1;
            end else begin
                cap    = 1'b1;
                pc_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)         pc_q <= RESET_PC;
        else if (redir_ok) pc_q <= redir_tgt;
        else if (pc_inc)   pc_q <= pc_q + 32'd4;
    end

    assign imem_pc      = pc_q;
    assign slot_d.valid = 1'b1;
    assign slot_d.pc    = pc_q;
    assign slot_d.inst  = imem_inst;

    if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
        .clk   (clk),
        .reset (reset),
        .load  (cap),
        .flush (flush),
        .d     (slot_d),
        .q     (slot_q)
    );

    assign if_id_valid = slot_q.valid;
    assign if_id_pc    = slot_q.pc;
    assign if_id_inst  = slot_q.inst;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a capture scoreboard and a small instruction ROM.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0020_81B3;
    localparam logic [31:0] I4  = 32'h4041_82B3;
    localparam logic [31:0] I8  = 32'h0053_2023;
    localparam logic [31:0] IC  = 32'h0003_2383;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_pc, imem_inst;
    logic        stall = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_id_valid, halted, misalign_err;
    logic [31:0] if_id_pc, if_id_inst;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];

    fetch_unit dut (
        .clk(clk), .reset(reset), .imem_pc(imem_pc), .imem_inst(imem_inst),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_inst(if_id_inst),
        .halted(halted), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // Test image plus one extra row at the top of memory for the wrap check.
    always_comb begin
        case (imem_pc)
            32'h0000_0000: imem_inst = I0;
            32'h0000_0004: imem_inst = I4;
            32'h0000_0008: imem_inst = I8;
            32'h0000_000C: imem_inst = IC;
            32'hFFFF_FFFC: imem_inst = NOP;
            default:       imem_inst = 32'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // One clock: drive inputs, optionally push an expected capture, then sample
    // 1ns after the edge and pop when the DUT shows a fresh capture.
    task automatic cyc(input logic st, input logic rv, input logic [31:0] rpc,
                       input logic cap, input logic [31:0] cpc, input logic [31:0] cinst,
                       input logic ev, input logic [31:0] epc);
        logic [63:0] e;
        stall = st; redirect_valid = rv; redirect_pc = rpc;
        if (cap) sb_q.push_back({cpc, cinst});
        @(posedge clk); #1;
        chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, ev});
        chk("imem_pc", imem_pc, epc);
        if (if_id_valid && !st && !rv && !reset) begin
            if (sb_q.size() == 0) chk("sb_spurious", 32'd1, 32'd0);
            else begin
                e = sb_q.pop_front();
                chk("if_id_pc", if_id_pc, e[63:32]);
                chk("if_id_inst", if_id_inst, e[31:0]);
            end
        end
        stall = 1'b0; redirect_valid = 1'b0;
    endtask

    task automatic run(input logic [31:0] pc, input logic [31:0] inst);
        cyc(0, 0, 0, 1, pc, inst, 1, pc + 32'd4);
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'h0, if_id_valid}, 32'd0);
        chk("rst_inst", if_id_inst, NOP);
        chk("rst_pc", if_id_pc, 32'h0);
        chk("rst_imem_pc", imem_pc, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'd0);
        chk("rst_misalign", {31'h0, misalign_err}, 32'd0);
        reset = 1'b0;

        // BOOT bubble, then the four-word image, then halt on the zero row
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h0);
        run(32'h0, I0); run(32'h4, I4); run(32'h8, I8); run(32'hC, IC);
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h10);
        chk("halt_set", {31'h0, halted}, 32'd1);
        chk("halt_nop", if_id_inst, NOP);
        cyc(1, 0, 0, 0, 0, 0, 0, 32'h10);
        chk("halt_hold", {31'h0, halted}, 32'd1);

        // leave HALT via redirect; one bubble
        cyc(0, 1, 32'h0, 0, 0, 0, 0, 32'h0);
        chk("halt_clr", {31'h0, halted}, 32'd0);
        run(32'h0, I0); run(32'h4, I4);

        // stall three cycles holding (0x4, sub)
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0, 0, 1, 32'h8);
            chk("stall_pc", if_id_pc, 32'h4);
            chk("stall_inst", if_id_inst, I4);
        end
        run(32'h8, I8);

        // redirect beats stall; second one taken while at 0x8
        cyc(1, 1, 32'h8, 0, 0, 0, 0, 32'h8);
        cyc(1, 1, 32'h0, 0, 0, 0, 0, 32'h0);
        chk("redir_nop", if_id_inst, NOP);
        run(32'h0, I0); run(32'h4, I4); run(32'h8, I8);

        // reset mid-run at 0xC overrides stall and redirect
        reset = 1'b1;
        cyc(1, 1, 32'h8, 0, 0, 0, 0, 32'h0);
        chk("mrst_inst", if_id_inst, NOP);
        chk("mrst_halted", {31'h0, halted}, 32'd0);
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h0);
        run(32'h0, I0);

        // misaligned redirect target 0x6
`ifdef FETCH_MISALIGN_CHK_EN
        cyc(0, 1, 32'h6, 0, 0, 0, 0, 32'h4);
        chk("mis_err", {31'h0, misalign_err}, 32'd1);
        chk("mis_halt", {31'h0, halted}, 32'd1);
        cyc(0, 1, 32'h4, 0, 0, 0, 0, 32'h4);
        chk("mis_sticky", {31'h0, misalign_err}, 32'd1);
        chk("mis_unhalt", {31'h0, halted}, 32'd0);
`else
        cyc(0, 1, 32'h6, 0, 0, 0, 0, 32'h4);
        chk("mis_err", {31'h0, misalign_err}, 32'd0);
        chk("mis_halt", {31'h0, halted}, 32'd0);
`endif
        run(32'h4, I4);

        // PC wraps from 0xFFFFFFFC to 0
        cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC);
        run(32'hFFFF_FFFC, NOP);
        run(32'h0, I0);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
